// File: rtl/alu_issue_ctrl.sv
// Issue stage for a registered 8-bit ALU: accepts instruction words, reads operands from a 4-entry register file, and writes the ALU result back two cycles later.
// Latency: LOADI/NOP/illegal take 1 cycle; ADD/SUB take 3 cycles accept-to-accept. Backpressure: instr_ready is high only in IDLE.
module alu_issue_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           instr,
    input  logic                  instr_valid,
    output logic                  instr_ready,
    output logic [3:0]            alu_opcode,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    output logic                  wb_valid,
    output logic [1:0]            wb_addr,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  illegal,
    output logic [7:0]            illegal_cnt,
    input  logic [1:0]            dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_LOADI = 4'b1000;
    localparam logic [3:0] OP_NOP   = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_regs [0:NUM_REGS-1];
    logic [1:0]            r_rd;
    logic [3:0]            r_alu_opcode;
    logic [DATA_WIDTH-1:0] r_alu_a;
    logic [DATA_WIDTH-1:0] r_alu_b;
    logic                  r_wb_valid;
    logic [1:0]            r_wb_addr;
    logic [DATA_WIDTH-1:0] r_wb_data;
    logic                  r_illegal;
    logic [7:0]            r_illegal_cnt;

    logic       w_accept;
    logic       w_is_alu;
    logic [3:0] w_op;
    logic [1:0] w_rd;
    logic [1:0] w_ra;
    logic [1:0] w_rb;

    assign w_op     = instr[15:12];
    assign w_rd     = instr[11:10];
    assign w_ra     = instr[9:8];
    assign w_rb     = instr[7:6];
    assign w_accept = instr_valid && (r_state == S_IDLE);
    assign w_is_alu = (w_op == OP_ADD) || (w_op == OP_SUB);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_is_alu) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
            r_rd          <= '0;
            r_alu_opcode  <= OP_NOP;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_addr     <= '0;
            r_wb_data     <= '0;
            r_illegal     <= 1'b0;
            r_illegal_cnt <= '0;
        end else begin
            r_wb_valid <= 1'b0;
            r_illegal  <= 1'b0;
            if (r_state == S_IDLE && w_accept) begin
                case (w_op)
                    OP_ADD, OP_SUB: begin
                        r_alu_opcode <= w_op;
                        r_alu_a      <= r_regs[w_ra];
                        r_alu_b      <= r_regs[w_rb];
                        r_rd         <= w_rd;
                    end
                    OP_LOADI: begin
                        r_regs[w_rd] <= DATA_WIDTH'(instr[7:0]);
                        r_wb_valid   <= 1'b1;
                        r_wb_addr    <= w_rd;
                        r_wb_data    <= DATA_WIDTH'(instr[7:0]);
                    end
                    OP_NOP: ;
                    default: begin
                        r_illegal <= 1'b1;
                        if (r_illegal_cnt != 8'hFF) r_illegal_cnt <= r_illegal_cnt + 8'd1;
                    end
                endcase
            end else if (r_state == S_WB) begin
                // Park the opcode at NOP so the ALU does not treat the held op as a new one.
                r_regs[r_rd] <= alu_result;
                r_wb_valid   <= 1'b1;
                r_wb_addr    <= r_rd;
                r_wb_data    <= alu_result;
                r_alu_opcode <= OP_NOP;
            end
        end
    end

    assign instr_ready = (r_state == S_IDLE);
    assign alu_opcode  = r_alu_opcode;
    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign wb_valid    = r_wb_valid;
    assign wb_addr     = r_wb_addr;
    assign wb_data     = r_wb_data;
    assign illegal     = r_illegal;
    assign illegal_cnt = r_illegal_cnt;
    assign dbg_data    = r_regs[dbg_addr];

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed and random instruction streams checked against an
// architectural register-file model, with a simple registered ALU attached.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  alu_opcode;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic [7:0]  alu_result = 8'h00;
    logic        wb_valid;
    logic [1:0]  wb_addr;
    logic [7:0]  wb_data;
    logic        illegal;
    logic [7:0]  illegal_cnt;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    int ref_regs [4];
    int ref_cnt;

    alu_issue_ctrl dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .illegal(illegal), .illegal_cnt(illegal_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    // Registered ALU: result appears the edge after it samples opcode/operands.
    always_ff @(posedge clk) begin
        if (alu_opcode == 4'b0000)      alu_result <= alu_a + alu_b;
        else if (alu_opcode == 4'b0001) alu_result <= alu_a - alu_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int k = 0;
        while (instr_ready !== 1'b1 && k < 10) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 10) chk("ready_timeout", 32'(instr_ready), 32'd1);
    endtask

    task automatic check_all_regs(input string tag);
        for (int r = 0; r < 4; r++) begin
            dbg_addr = 2'(r);
            #1;
            chk(tag, 32'(dbg_data), 32'(ref_regs[r]));
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 4; r++) ref_regs[r] = 0;
        ref_cnt = 0;
    endtask

    // Issue one instruction and check every cycle of its execution against the model.
    // hold: keep instr_valid high with junk words while the block is busy.
    task automatic run(input logic [15:0] w, input bit hold);
        logic [3:0] op;
        logic [1:0] rd, ra, rb;
        int exp_v;
        op = w[15:12]; rd = w[11:10]; ra = w[9:8]; rb = w[7:6];
        wait_ready();
        instr = w;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        if (op == 4'b0000 || op == 4'b0001) begin
            exp_v = (op == 4'b0000) ? (ref_regs[ra] + ref_regs[rb]) % 256
                                    : (ref_regs[ra] - ref_regs[rb] + 256) % 256;
            if (hold) begin instr_valid = 1'b1; instr = 16'($urandom); end
            chk("e0_opcode", 32'(alu_opcode), 32'(op));
            chk("e0_a", 32'(alu_a), 32'(ref_regs[ra]));
            chk("e0_b", 32'(alu_b), 32'(ref_regs[rb]));
            chk("e0_ready", 32'(instr_ready), 32'd0);
            chk("e0_wb", 32'(wb_valid), 32'd0);
            @(posedge clk); #1;
            if (hold) instr = 16'($urandom);
            chk("e1_opcode", 32'(alu_opcode), 32'(op));
            chk("e1_a", 32'(alu_a), 32'(ref_regs[ra]));
            chk("e1_b", 32'(alu_b), 32'(ref_regs[rb]));
            chk("e1_ready", 32'(instr_ready), 32'd0);
            dbg_addr = rd; #1;
            chk("dbg_old", 32'(dbg_data), 32'(ref_regs[rd]));
            @(posedge clk); #1;
            instr_valid = 1'b0;
            chk("e2_wb_valid", 32'(wb_valid), 32'd1);
            chk("e2_wb_addr", 32'(wb_addr), 32'(rd));
            chk("e2_wb_data", 32'(wb_data), 32'(exp_v));
            chk("e2_opcode_nop", 32'(alu_opcode), 32'hF);
            chk("e2_ready", 32'(instr_ready), 32'd1);
            chk("dbg_new", 32'(dbg_data), 32'(exp_v));
            ref_regs[rd] = exp_v;
            chk("no_illegal", 32'(illegal), 32'd0);
        end else if (op == 4'b1000) begin
            ref_regs[rd] = int'(w[7:0]);
            chk("ld_wb_valid", 32'(wb_valid), 32'd1);
            chk("ld_wb_addr", 32'(wb_addr), 32'(rd));
            chk("ld_wb_data", 32'(wb_data), 32'(ref_regs[rd]));
            chk("ld_ready", 32'(instr_ready), 32'd1);
            chk("no_illegal", 32'(illegal), 32'd0);
        end else if (op == 4'b1111) begin
            chk("nop_wb", 32'(wb_valid), 32'd0);
            chk("nop_ready", 32'(instr_ready), 32'd1);
            chk("no_illegal", 32'(illegal), 32'd0);
        end else begin
            if (ref_cnt < 255) ref_cnt++;
            chk("ill_pulse", 32'(illegal), 32'd1);
            chk("ill_wb", 32'(wb_valid), 32'd0);
        end
        chk("illegal_cnt", 32'(illegal_cnt), 32'(ref_cnt));
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb);
        return {op, rd, ra, rb, 6'b0};
    endfunction

    function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
        return {4'b1000, rd, 2'b00, imm};
    endfunction

    initial begin
        logic [15:0] w;
        int sel;
        reset = 1'b1; instr = '0; instr_valid = 1'b0; dbg_addr = '0;
        repeat (2) @(posedge clk);
        #1; reset = 1'b0;
        model_reset();

        // Reset state
        check_all_regs("reset_reg");
        chk("reset_ready", 32'(instr_ready), 32'd1);
        chk("reset_cnt", 32'(illegal_cnt), 32'd0);
        chk("reset_opcode", 32'(alu_opcode), 32'hF);
        chk("reset_wb", 32'(wb_valid), 32'd0);

        // Basic add
        run(ldi(2'd1, 8'h05), 1'b0);
        run(ldi(2'd2, 8'h03), 1'b0);
        run(mk(4'b0000, 2'd3, 2'd1, 2'd2), 1'b0);
        chk("add_r3", 32'(ref_regs[3]), 32'h08);

        // Underflow and overflow wrap, rd aliasing ra
        run(ldi(2'd0, 8'h02), 1'b0);
        run(ldi(2'd1, 8'h03), 1'b0);
        run(mk(4'b0001, 2'd2, 2'd0, 2'd1), 1'b0);
        run(ldi(2'd0, 8'hFF), 1'b0);
        run(ldi(2'd1, 8'h01), 1'b0);
        run(mk(4'b0000, 2'd0, 2'd0, 2'd1), 1'b0);
        check_all_regs("wrap_reg");

        // Illegal saturation
        for (int i = 0; i < 300; i++) run({4'b0101, 12'($urandom)}, 1'b0);
        chk("ill_sat", 32'(illegal_cnt), 32'd255);
        check_all_regs("ill_regs");

        // Busy-hold with changing words, then NOP consumed in one cycle
        run(mk(4'b0001, 2'd3, 2'd2, 2'd0), 1'b1);
        run(16'hF000, 1'b0);
        run(ldi(2'd1, 8'h5A), 1'b0);
        check_all_regs("hold_regs");

        // Random stream
        for (int i = 0; i < 60; i++) begin
            sel = $urandom_range(0, 4);
            w = 16'($urandom);
            case (sel)
                0: w[15:12] = 4'b0000;
                1: w[15:12] = 4'b0001;
                2: w[15:12] = 4'b1000;
                3: w[15:12] = 4'b1111;
                default: w[15:12] = 4'($urandom_range(2, 7));
            endcase
            run(w, 1'($urandom_range(0, 1)));
        end
        check_all_regs("rand_regs");

        // Reset during EXEC discards the in-flight result
        run(ldi(2'd2, 8'h11), 1'b0);
        instr = mk(4'b0000, 2'd2, 2'd2, 2'd2);
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("rst_exec_busy", 32'(instr_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        chk("rst_exec_ready", 32'(instr_ready), 32'd1);
        chk("rst_exec_opcode", 32'(alu_opcode), 32'hF);
        chk("rst_exec_cnt", 32'(illegal_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rst_exec_no_wb", 32'(wb_valid), 32'd0);
            @(posedge clk); #1;
        end
        check_all_regs("rst_exec_regs");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
